// File: rtl/mips_pkg.sv
// Shared types and constants for the CPU-to-pad memory bridge.
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPTURE,
    RELEASE,
    DONE,
    ERR
  } bridge_state_t;

  // Read data returned on a timed-out transaction; sliced to DWIDTH at use.
  localparam logic [63:0] ERR_DATA = '1;

endpackage

// File: rtl/mem_bridge_sync2.sv
// Two-flop synchronizer for the asynchronous pad acknowledge.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// CPU memread/memwrite to external pad strobe/acknowledge handshake bridge.
// Define MEM_BRIDGE_TIMEOUT_EN to enable the acknowledge timeout and ERR state.
module mem_bridge
  import mips_pkg::*;
#(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [AWIDTH-1:0]        cpu_adr,
  input  logic [DWIDTH-1:0]        cpu_wdata,
  output logic [DWIDTH-1:0]        cpu_rdata,
  output logic                     cpu_rvalid,
  output logic                     cpu_stall,
  input  logic [DWIDTH-1:0]        pad_in,
  input  logic                     pad_ack,
  output logic [AWIDTH+DWIDTH-1:0] pad_out,
  output logic [1:0]               pad_ctrl,
  output logic [AWIDTH+DWIDTH+1:0] pad_oeb,
  output logic                     err
);

  bridge_state_t state, next_state;

  logic              ack_s;
  logic [AWIDTH-1:0] adr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              we_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              latch_en;
  logic              capture_en;
  logic              strobe;
  logic              rvalid;
  logic              stall;

  sync2 u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d     (pad_ack),
    .q     (ack_s)
  );

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;
  logic          timed_out;
  logic          err_q;

  assign timed_out = (cnt == CW'(TIMEOUT));

  // Counts consecutive cycles spent waiting in REQ or RELEASE; clears on any move.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state == REQ || state == RELEASE) && next_state == state) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (next_state == ERR) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    stall      = 1'b1;
    strobe     = 1'b0;
    rvalid     = 1'b0;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    case (state)
      IDLE: begin
        stall = cpu_req;
        if (cpu_req) begin
          latch_en   = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        strobe = 1'b1;
        if (ack_s) begin
          next_state = CAPTURE;
`ifdef MEM_BRIDGE_TIMEOUT_EN
        end else if (timed_out) begin
          next_state = ERR;
`endif
        end
      end
      CAPTURE: begin
        capture_en = ~we_q;
        next_state = RELEASE;
      end
      RELEASE: begin
        if (!ack_s) begin
          next_state = DONE;
`ifdef MEM_BRIDGE_TIMEOUT_EN
        end else if (timed_out) begin
          next_state = ERR;
`endif
        end
      end
      DONE: begin
        stall      = 1'b0;
        rvalid     = ~we_q;
        next_state = IDLE;
      end
`ifdef MEM_BRIDGE_TIMEOUT_EN
      ERR: begin
        rvalid     = ~we_q;
        next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      adr_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (latch_en) begin
      adr_q   <= cpu_adr;
      wdata_q <= cpu_wdata;
      we_q    <= cpu_we;
    end
  end

  // ERR data is loaded on entry so it is already visible during the ERR pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (capture_en) begin
      rdata_q <= pad_in;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    end else if (next_state == ERR) begin
      rdata_q <= ERR_DATA[DWIDTH-1:0];
`endif
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid;
  assign cpu_stall  = stall;
  assign pad_out    = {adr_q, wdata_q};
  assign pad_ctrl   = {we_q, strobe};
  assign pad_oeb    = '0;

endmodule
